btn_led_ctrl: RTL and testbench

- Parametrised button-to-LED controller for the Zed board user I/O path.
- Per bit: synchronises the raw button inputs, debounces them, and drives the LEDs in one of four run-time selectable modes: direct, toggle, sticky latch, press counter.
- Sits between the board pins and the LED pins; its debounced state and press pulses are exported for debug probes.

---
 rtl/btn_led_ctrl.sv | 122 ++++++++++++
 tb/tb_btn_led_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_led_ctrl.sv
// Button-to-LED controller: per-channel synchroniser, debouncer and four LED modes.
// Optional PWM output gating is compiled in with `define BTNLED_PWM_EN.
module btn_led_ctrl #(
  parameter  int WIDTH           = 8,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 1000000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             GCLK,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Btn,
  input  logic [1:0]       Mode,
  input  logic             Clr,
  input  logic [7:0]       Duty,
  output logic [WIDTH-1:0] Led,
  output logic [WIDTH-1:0] Press,
  output logic [WIDTH-1:0] Stable
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_LATCH  = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  sync;
  logic [CNT_W-1:0]                  cnt [WIDTH];
  logic [WIDTH-1:0]                  stable_d;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  s_q;
  logic [WIDTH-1:0]                  s_next;
  mode_t                             mode_q;
  logic                              mode_change;

  assign sync = sync_r[SYNC_STAGES-1];

  always_ff @(posedge GCLK or posedge Rst) begin
    if (Rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], Btn};
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge GCLK or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
      Stable <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync[i] == Stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          Stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise        = Stable & ~stable_d;
  assign mode_change = (Mode != mode_q);

  always_comb begin
    s_next = s_q;
    if (Clr || mode_change) begin
      s_next = '0;
    end else begin
      unique case (mode_q)
        MODE_DIRECT: s_next = Stable;
        MODE_TOGGLE: s_next = s_q ^ rise;
        MODE_LATCH:  s_next = s_q | rise;
        MODE_COUNT:  if (|rise) s_next = s_q + 1'b1;
        default:     s_next = s_q;
      endcase
    end
  end

  always_ff @(posedge GCLK or posedge Rst) begin
    if (Rst) begin
      stable_d <= '0;
      Press    <= '0;
      s_q      <= '0;
      mode_q   <= MODE_DIRECT;
    end else begin
      stable_d <= Stable;
      Press    <= rise;
      s_q      <= s_next;
      mode_q   <= mode_t'(Mode);
    end
  end

`ifdef BTNLED_PWM_EN
  logic [7:0]       pwm_cnt;
  logic [WIDTH-1:0] led_q;

  // Gate from s_next so the LED register lands on the same edge as S.
  always_ff @(posedge GCLK or posedge Rst) begin
    if (Rst) begin
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      led_q   <= s_next & {WIDTH{pwm_cnt < Duty}};
    end
  end

  assign Led = led_q;
`else
  logic unused_duty;
  assign unused_duty = ^Duty;
  assign Led         = s_q;
`endif

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed self-checking bench for btn_led_ctrl (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_btn_led_ctrl;

  logic       GCLK = 1'b0;
  logic       Rst;
  logic [7:0] Btn;
  logic [1:0] Mode;
  logic       Clr;
  logic [7:0] Duty;
  logic [7:0] Led;
  logic [7:0] Press;
  logic [7:0] Stable;

  int checks = 0;
  int errors = 0;
  int pulses;
  logic [7:0] press_seen;

  always #5 GCLK = ~GCLK;

  btn_led_ctrl #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .GCLK(GCLK),
    .Rst(Rst),
    .Btn(Btn),
    .Mode(Mode),
    .Clr(Clr),
    .Duty(Duty),
    .Led(Led),
    .Press(Press),
    .Stable(Stable)
  );

  task automatic tick;
    @(posedge GCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic hold(input int n, input logic [7:0] m);
    repeat (n) begin
      tick();
      if ((Press & m) != 8'h00) pulses++;
      press_seen = press_seen | Press;
    end
  endtask

  task automatic press(input logic [7:0] m);
    pulses     = 0;
    press_seen = 8'h00;
    Btn = Btn | m;
    hold(8, m);
    Btn = Btn & ~m;
    hold(8, m);
  endtask

  task automatic test_reset;
    Rst = 1'b0; Btn = 8'h00; Mode = 2'b00; Clr = 1'b0; Duty = 8'h00;
    #2 Rst = 1'b1;
    ticks(2);
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL reset_led got=%h exp=00", Led); end
    checks++; if (Press !== 8'h00) begin errors++; $display("FAIL reset_press got=%h exp=00", Press); end
    checks++; if (Stable !== 8'h00) begin errors++; $display("FAIL reset_stable got=%h exp=00", Stable); end
    Rst = 1'b0;
    ticks(2);
  endtask

  task automatic test_direct_latency;
    logic [7:0] exp_led, exp_press;
    logic       exp_st;
    Btn = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_st    = (k >= 6);
      exp_led   = (k == 7) ? 8'h01 : 8'h00;
      exp_press = (k == 7) ? 8'h01 : 8'h00;
      checks++; if (Stable[0] !== exp_st) begin errors++; $display("FAIL latency_stable k=%0d got=%b exp=%b", k, Stable[0], exp_st); end
      checks++; if (Led !== exp_led) begin errors++; $display("FAIL latency_led k=%0d got=%h exp=%h", k, Led, exp_led); end
      checks++; if (Press !== exp_press) begin errors++; $display("FAIL latency_press k=%0d got=%h exp=%h", k, Press, exp_press); end
    end
    ticks(2);
    checks++; if (Led !== 8'h01) begin errors++; $display("FAIL direct_hold_led got=%h exp=01", Led); end
    checks++; if (Press !== 8'h00) begin errors++; $display("FAIL direct_single_press got=%h exp=00", Press); end
  endtask

  task automatic test_glitch;
    Btn = 8'h09;
    ticks(3);
    Btn = 8'h01;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (Stable !== 8'h01) begin errors++; $display("FAIL glitch_stable k=%0d got=%h exp=01", k, Stable); end
      checks++; if (Press !== 8'h00) begin errors++; $display("FAIL glitch_press k=%0d got=%h exp=00", k, Press); end
      checks++; if (Led !== 8'h01) begin errors++; $display("FAIL glitch_led k=%0d got=%h exp=01", k, Led); end
    end
    Btn = 8'h00;
    ticks(10);
    checks++; if (Stable !== 8'h00) begin errors++; $display("FAIL release_stable got=%h exp=00", Stable); end
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL release_led got=%h exp=00", Led); end
  endtask

  task automatic test_toggle;
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h04; exp_seq[1] = 8'h00; exp_seq[2] = 8'h04;
    Mode = 2'b01;
    ticks(3);
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL toggle_start got=%h exp=00", Led); end
    for (int n = 0; n < 3; n++) begin
      press(8'h04);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL toggle_pulses n=%0d got=%0d exp=1", n, pulses); end
      checks++; if (Led !== exp_seq[n]) begin errors++; $display("FAIL toggle_led n=%0d got=%h exp=%h", n, Led, exp_seq[n]); end
    end
  endtask

  task automatic test_latch;
    Mode = 2'b10;
    ticks(3);
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL latch_modechg got=%h exp=00", Led); end
    press(8'h01);
    checks++; if (Led !== 8'h01) begin errors++; $display("FAIL latch_first got=%h exp=01", Led); end
    press(8'h80);
    checks++; if (Led !== 8'h81) begin errors++; $display("FAIL latch_second got=%h exp=81", Led); end
    Clr = 1'b1;
    tick();
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL latch_clr got=%h exp=00", Led); end
    Clr = 1'b0;
    ticks(3);
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL latch_after_clr got=%h exp=00", Led); end
  endtask

  task automatic test_counter;
    Mode = 2'b11;
    ticks(3);
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL count_modechg got=%h exp=00", Led); end
    press(8'h02);
    checks++; if (Led !== 8'h01) begin errors++; $display("FAIL count_first got=%h exp=01", Led); end
    repeat (254) press(8'h02);
    checks++; if (Led !== 8'hFF) begin errors++; $display("FAIL count_255 got=%h exp=FF", Led); end
    press(8'h22);
    checks++; if (press_seen !== 8'h22) begin errors++; $display("FAIL count_simul_press got=%h exp=22", press_seen); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL count_simul_cycles got=%0d exp=1", pulses); end
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL count_wrap got=%h exp=00", Led); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_led;
    repeat (42) press(8'h01);
    checks++; if (Led !== 8'h2A) begin errors++; $display("FAIL rst_precount got=%h exp=2A", Led); end
    Btn = 8'h02;
    ticks(3);
    #3 Rst = 1'b1;
    #1;
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL rst_async_led got=%h exp=00", Led); end
    checks++; if (Stable !== 8'h00) begin errors++; $display("FAIL rst_async_stable got=%h exp=00", Stable); end
    tick();
    Rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_led = (k == 7) ? 8'h01 : 8'h00;
      checks++; if (Led !== exp_led) begin errors++; $display("FAIL rst_recount k=%0d got=%h exp=%h", k, Led, exp_led); end
    end
    Btn = 8'h00;
    ticks(10);
  endtask

`ifdef BTNLED_PWM_EN
  task automatic test_pwm;
    int ones, zeros;
    Mode = 2'b10;
    ticks(3);
    Duty = 8'd255;
    press(8'hFF);
    Duty = 8'd64;
    ticks(2);
    ones = 0; zeros = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (Led === 8'hFF) ones++;
      if (Led === 8'h00) zeros++;
    end
    checks++; if (ones !== 64) begin errors++; $display("FAIL pwm_on got=%0d exp=64", ones); end
    checks++; if (zeros !== 192) begin errors++; $display("FAIL pwm_off got=%0d exp=192", zeros); end
    Duty = 8'd0;
    ticks(2);
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (Led !== 8'h00) ones++;
    end
    checks++; if (ones !== 0) begin errors++; $display("FAIL pwm_duty0 got=%0d exp=0", ones); end
  endtask
`endif

  initial begin
    test_reset();
    test_direct_latency();
    test_glitch();
    test_toggle();
    test_latch();
    test_counter();
    test_reset_mid();
`ifdef BTNLED_PWM_EN
    test_pwm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
